// File: rtl/branch_predict_unit.sv
// Branch prediction/resolution: direct-mapped BTB with saturating direction counters
// looked up in IF, compare-branch resolver in EX, registered redirect and statistics.
module branch_predict_unit #(
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_WD      = 2,
  parameter int STAT_WD     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        fetch_pc,
  output logic [31:0]        pred_pc,
  output logic               pred_taken,
  input  logic               ex_valid,
  input  logic [3:0]         ex_br_op,
  input  logic [31:0]        ex_pc,
  input  logic [31:0]        ex_pred_pc,
  input  logic [31:0]        ex_src1,
  input  logic [31:0]        ex_src2,
  input  logic               ex_src_ready,
  input  logic [31:0]        ex_offset,
  output logic               resolve_stall,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic [STAT_WD-1:0] br_count,
  output logic [STAT_WD-1:0] mispred_count
);
  localparam int IDX_WD = $clog2(BTB_ENTRIES);
  localparam int TAG_WD = 30 - IDX_WD;
  localparam logic [CNT_WD-1:0] CNT_INIT = CNT_WD'(1) << (CNT_WD - 1);

  typedef struct packed {
    logic              valid;
    logic [TAG_WD-1:0] tag;
    logic [31:0]       target;
    logic              uncond;
    logic [CNT_WD-1:0] cnt;
  } btb_ent_t;

  btb_ent_t r_btb [BTB_ENTRIES];

  // IF lookup
  logic [IDX_WD-1:0] w_fidx;
  btb_ent_t          w_fent;
  logic              w_fhit, w_ftake;

  assign w_fidx     = fetch_pc[IDX_WD+1:2];
  assign w_fent     = r_btb[w_fidx];
  assign w_fhit     = w_fent.valid && (w_fent.tag == fetch_pc[31:IDX_WD+2]);
  assign w_ftake    = ~reset & w_fhit & (w_fent.uncond | w_fent.cnt[CNT_WD-1]);
  assign pred_pc    = w_ftake ? w_fent.target : fetch_pc + 32'd4;
  assign pred_taken = w_ftake;

  // EX decode and resolution
  logic        w_taken, w_needs_src, w_is_br, w_uncond;
  logic        w_eq, w_lts, w_ltu;
  logic        w_resolve, w_mispred;
  logic [31:0] w_next;

  assign w_eq  = (ex_src1 == ex_src2);
  assign w_lts = ($signed(ex_src1) < $signed(ex_src2));
  assign w_ltu = (ex_src1 < ex_src2);

  always_comb begin
    w_taken     = 1'b0;
    w_needs_src = 1'b0;
    w_is_br     = 1'b1;
    w_uncond    = 1'b0;
    case (ex_br_op)
      4'd1:      begin w_taken = 1'b1; w_uncond = 1'b1; w_needs_src = 1'b1; end
      4'd2, 4'd3: begin w_taken = 1'b1; w_uncond = 1'b1; end
      4'd4:      begin w_taken = w_eq;   w_needs_src = 1'b1; end
      4'd5:      begin w_taken = ~w_eq;  w_needs_src = 1'b1; end
      4'd6:      begin w_taken = w_lts;  w_needs_src = 1'b1; end
      4'd7:      begin w_taken = ~w_lts; w_needs_src = 1'b1; end
      4'd8:      begin w_taken = w_ltu;  w_needs_src = 1'b1; end
      4'd9:      begin w_taken = ~w_ltu; w_needs_src = 1'b1; end
      default:   w_is_br = 1'b0;
    endcase
  end

  assign w_next        = (ex_br_op == 4'd1) ? ex_src1 + ex_offset :
                         w_taken            ? ex_pc + ex_offset   : ex_pc + 32'd4;
  assign resolve_stall = ex_valid & ~ex_src_ready & w_needs_src;
  assign w_resolve     = ex_valid & ~resolve_stall;
  // Op 0 is checked too, so a false BTB hit on a non-branch still redirects.
  assign w_mispred     = (w_next != ex_pred_pc);

  logic [IDX_WD-1:0] w_eidx;
  logic [TAG_WD-1:0] w_etag;
  btb_ent_t          w_eent;
  logic              w_ehit;

  assign w_eidx = ex_pc[IDX_WD+1:2];
  assign w_etag = ex_pc[31:IDX_WD+2];
  assign w_eent = r_btb[w_eidx];
  assign w_ehit = w_eent.valid && (w_eent.tag == w_etag);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) r_btb[i] <= '0;
    end else if (w_resolve) begin
      if (w_taken) begin
        if (w_ehit) begin
          r_btb[w_eidx].target <= w_next;
          r_btb[w_eidx].uncond <= w_uncond;
          if (w_eent.cnt != '1) r_btb[w_eidx].cnt <= w_eent.cnt + CNT_WD'(1);
        end else begin
          r_btb[w_eidx] <= '{valid: 1'b1, tag: w_etag, target: w_next,
                             uncond: w_uncond, cnt: CNT_INIT};
        end
      end else if (w_is_br) begin
        if (w_ehit && w_eent.cnt != '0) r_btb[w_eidx].cnt <= w_eent.cnt - CNT_WD'(1);
      end else if (w_ehit) begin
        r_btb[w_eidx].valid <= 1'b0;
      end
    end
  end

  // Registered redirect and saturating statistics
  logic               r_redir_v;
  logic [31:0]        r_redir_pc;
  logic [STAT_WD-1:0] r_br_cnt, r_mis_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_redir_v  <= 1'b0;
      r_redir_pc <= '0;
      r_br_cnt   <= '0;
      r_mis_cnt  <= '0;
    end else begin
      r_redir_v <= w_resolve & w_mispred;
      if (w_resolve & w_mispred) r_redir_pc <= w_next;
      if (w_resolve & w_is_br & (r_br_cnt != '1))    r_br_cnt  <= r_br_cnt + STAT_WD'(1);
      if (w_resolve & w_mispred & (r_mis_cnt != '1)) r_mis_cnt <= r_mis_cnt + STAT_WD'(1);
    end
  end

  assign redirect_valid = r_redir_v;
  assign redirect_pc    = r_redir_pc;
  assign br_count       = r_br_cnt;
  assign mispred_count  = r_mis_cnt;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit; expected redirects are queued at issue
// and compared one cycle later when the registered redirect appears.
module tb_branch_predict_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc, pred_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic [3:0]  ex_br_op;
  logic [31:0] ex_pc, ex_pred_pc, ex_src1, ex_src2, ex_offset;
  logic        ex_src_ready, resolve_stall, redirect_valid;
  logic [31:0] redirect_pc, br_count, mispred_count;

  branch_predict_unit #(.BTB_ENTRIES(16), .CNT_WD(2), .STAT_WD(32)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .ex_valid(ex_valid), .ex_br_op(ex_br_op),
    .ex_pc(ex_pc), .ex_pred_pc(ex_pred_pc), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_src_ready(ex_src_ready), .ex_offset(ex_offset),
    .resolve_stall(resolve_stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic v; logic [31:0] pc; } exp_t;
  exp_t exp_q[$];
  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare the redirect produced by the previous cycle's work.
  task automatic cyc();
    exp_t e;
    @(posedge clk); #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("redir_v", {31'd0, redirect_valid}, {31'd0, e.v});
      if (e.v) chk("redir_pc", redirect_pc, e.pc);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] pred,
                       input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] off,
                       input logic rdy, input logic ev, input logic [31:0] epc);
    ex_valid = 1'b1; ex_br_op = op; ex_pc = pc; ex_pred_pc = pred;
    ex_src1 = s1; ex_src2 = s2; ex_offset = off; ex_src_ready = rdy;
    exp_q.push_back('{ev, epc});
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_br_op = 4'd0;
    exp_q.push_back('{1'b0, 32'd0});
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] epred,
                      input logic etk);
    fetch_pc = pc; #1;
    chk({tag, "_pc"}, pred_pc, epred);
    chk({tag, "_tk"}, {31'd0, pred_taken}, {31'd0, etk});
  endtask

  task automatic stats(input logic [31:0] eb, input logic [31:0] em);
    chk("br_count", br_count, eb);
    chk("mispred_count", mispred_count, em);
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_br_op = '0; ex_pc = '0; ex_pred_pc = '0;
    ex_src1 = '0; ex_src2 = '0; ex_offset = '0; ex_src_ready = 1'b0;
    look("rst_hold", 32'h1c000000, 32'h1c000004, 1'b0);
    idle(); cyc();
    idle(); cyc();
    reset = 1'b0;
    stats(0, 0);
    chk("rst_redir_pc", redirect_pc, 32'd0);
    look("rst_lookup", 32'h1c000000, 32'h1c000004, 1'b0);
    idle(); cyc();

    // beq taken: allocate weakly taken, lookup same cycle sees old contents
    issue(4'd4, 32'h1c000010, 32'h1c000014, 32'd5, 32'd5, 32'h20, 1'b1, 1'b1, 32'h1c000030);
    look("beq_old", 32'h1c000010, 32'h1c000014, 1'b0);
    cyc();
    look("beq_new", 32'h1c000010, 32'h1c000030, 1'b1);
    stats(1, 1);
    idle(); cyc();

    // not taken three times: cnt 2->1->0->0, then one taken must leave it below MSB
    issue(4'd4, 32'h1c000010, 32'h1c000030, 32'd5, 32'd6, 32'h20, 1'b1, 1'b1, 32'h1c000014);
    cyc();
    look("cnt1", 32'h1c000010, 32'h1c000014, 1'b0);
    issue(4'd4, 32'h1c000010, 32'h1c000014, 32'd5, 32'd6, 32'h20, 1'b1, 1'b0, 32'd0);
    cyc();
    issue(4'd4, 32'h1c000010, 32'h1c000014, 32'd5, 32'd6, 32'h20, 1'b1, 1'b0, 32'd0);
    cyc();
    issue(4'd4, 32'h1c000010, 32'h1c000014, 32'd7, 32'd7, 32'h20, 1'b1, 1'b1, 32'h1c000030);
    cyc();
    look("cnt_floor", 32'h1c000010, 32'h1c000014, 1'b0);
    stats(5, 3);

    // signed vs unsigned compares, back to back; 0x100/0x200/0x300 share index 0
    issue(4'd6, 32'h1c000100, 32'h1c000104, 32'hFFFFFFFF, 32'd1, 32'h40, 1'b1, 1'b1, 32'h1c000140);
    cyc();
    issue(4'd8, 32'h1c000200, 32'h1c000204, 32'hFFFFFFFF, 32'd1, 32'h40, 1'b1, 1'b0, 32'd0);
    cyc();
    look("blt_tgt", 32'h1c000100, 32'h1c000140, 1'b1);
    look("bltu_miss", 32'h1c000200, 32'h1c000204, 1'b0);
    issue(4'd9, 32'h1c000300, 32'h1c000304, 32'hFFFFFFFF, 32'd1, 32'h10, 1'b1, 1'b1, 32'h1c000310);
    cyc();
    stats(8, 5);

    // jirl waits for operands; b does not
    for (int i = 0; i < 2; i++) begin
      issue(4'd1, 32'h1c000020, 32'h1c000024, 32'd0, 32'd0, 32'd8, 1'b0, 1'b0, 32'd0);
      #1 chk("jirl_stall", {31'd0, resolve_stall}, 32'd1);
      cyc();
    end
    stats(8, 5);
    issue(4'd1, 32'h1c000020, 32'h1c000024, 32'h1c001000, 32'd0, 32'd8, 1'b1, 1'b1, 32'h1c001008);
    #1 chk("jirl_go", {31'd0, resolve_stall}, 32'd0);
    cyc();
    stats(9, 6);
    issue(4'd2, 32'h1c000044, 32'h1c000048, 32'd0, 32'd0, 32'h100, 1'b0, 1'b1, 32'h1c000144);
    #1 chk("b_nostall", {31'd0, resolve_stall}, 32'd0);
    cyc();
    stats(10, 7);

    // false hit on a non-branch: redirect to pc+4 and invalidate the entry
    look("jirl_hit", 32'h1c000020, 32'h1c001008, 1'b1);
    issue(4'd0, 32'h1c000020, 32'h1c001008, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h1c000024);
    cyc();
    look("alias_inval", 32'h1c000020, 32'h1c000024, 1'b0);
    stats(10, 8);

    // reset in the redirect cycle swallows the redirect of a mispredicting b
    reset = 1'b1;
    issue(4'd2, 32'h1c000044, 32'h1c000048, 32'd0, 32'd0, 32'h100, 1'b1, 1'b0, 32'd0);
    cyc();
    chk("rst_mid_pc", redirect_pc, 32'd0);
    stats(0, 0);
    reset = 1'b0;
    look("rst_btb_clear", 32'h1c000100, 32'h1c000104, 1'b0);
    idle(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
